i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_sync.sv | 24 ++
 rtl/i2c_target.sv | 185 ++++++++++++++++++
 tb/tb_i2c_target.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encodings and bus-level ACK/NACK values.
// Also used by i2cmaster benches so both sides agree on the encodings.
package i2c_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] ST_ADDR    = 4'd1;
    localparam logic [STATE_W-1:0] ST_ADDRACK = 4'd2;
    localparam logic [STATE_W-1:0] ST_PTR     = 4'd3;
    localparam logic [STATE_W-1:0] ST_PTRACK  = 4'd4;
    localparam logic [STATE_W-1:0] ST_WDATA   = 4'd5;
    localparam logic [STATE_W-1:0] ST_WACK    = 4'd6;
    localparam logic [STATE_W-1:0] ST_RDATA   = 4'd7;
    localparam logic [STATE_W-1:0] ST_RACK    = 4'd8;
    localparam logic [STATE_W-1:0] ST_IGNORE  = 4'd9;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // The target owns the bus in every state except IDLE and IGNORE.
    function automatic logic st_busy(input logic [STATE_W-1:0] st);
        return !((st == ST_IDLE) || (st == ST_IGNORE));
    endfunction

endpackage

// File: rtl/i2c_sync.sv
// Two-flop synchronizer for one asynchronous bus line, plus a history flop
// that turns the synchronized level into single-cycle rise/fall pulses.
module i2c_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // Idle I2C lines are high, so reset to 1 to avoid a false edge on release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 3'b111;
        else         sync_q <= {sync_q[1:0], line_i};
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C register-access target: 7-bit address, one pointer byte, then auto-incrementing
// writes or reads. Bus inputs are oversampled on CLOCK; i2cdao is an open-drain enable.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVADDR = 7'h20
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               i2cclk,
    input  logic               i2cdai,
    output logic               i2cdao,
    output logic [7:0]         regaddr,
    output logic [7:0]         regwdata,
    output logic               regwrite,
    output logic               regread,
    input  logic [7:0]         regrdata,
    output logic               busy,
    output logic [STATE_W-1:0] state_dbg
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync u_sync_scl (.clk_i(CLOCK), .rst_ni(RESET_N), .line_i(i2cclk),
                         .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
    i2c_sync u_sync_sda (.clk_i(CLOCK), .rst_ni(RESET_N), .line_i(i2cdai),
                         .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    logic [STATE_W-1:0] state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [6:0]         shift_q, shift_d;
    logic [7:0]         tx_q, tx_d;
    logic               phase_q, phase_d;
    logic               rw_q, rw_d;
    logic               dao_q, dao_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [7:0]         rx_byte;

    assign rx_byte = {shift_q, sda_lvl};

    // Strobes: regwrite/regread are single-CLOCK pulses with no back-pressure; regaddr and
    // regwdata are valid in the pulse cycle, regrdata is captured on the edge that ends regread.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        phase_d = phase_q;
        rw_d    = rw_q;
        dao_d   = dao_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        if (rd_q) tx_d = regrdata;
        if (stop_det) begin
            state_d = ST_IDLE;
            dao_d   = I2C_NACK;
            phase_d = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 3'd0;
            dao_d   = I2C_NACK;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
                    shift_d = rx_byte[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (state_q == ST_ADDR) begin
                            if (rx_byte[7:1] == DEVADDR) begin
                                state_d = ST_ADDRACK;
                                rw_d    = rx_byte[0];
                                rd_d    = rx_byte[0];
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else if (state_q == ST_PTR) begin
                            addr_d  = rx_byte;
                            state_d = ST_PTRACK;
                        end else begin
                            wdata_d = rx_byte;
                            wr_d    = 1'b1;
                            state_d = ST_WACK;
                        end
                    end
                end
                // phase_q separates the fall that starts the ACK from the fall that ends it.
                ST_ADDRACK, ST_PTRACK, ST_WACK: if (scl_fall) begin
                    if (!phase_q) begin
                        dao_d   = I2C_ACK;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        cnt_d   = 3'd0;
                        dao_d   = I2C_NACK;
                        if (state_q == ST_ADDRACK && rw_q) begin
                            state_d = ST_RDATA;
                            dao_d   = tx_q[7];
                            tx_d    = {tx_q[6:0], 1'b0};
                        end else if (state_q == ST_ADDRACK) begin
                            state_d = ST_PTR;
                        end else begin
                            state_d = ST_WDATA;
                            if (state_q == ST_WACK) addr_d = addr_q + 8'd1;
                        end
                    end
                end
                ST_RDATA: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        dao_d   = I2C_NACK;
                        cnt_d   = 3'd0;
                        state_d = ST_RACK;
                    end else begin
                        dao_d = tx_q[7];
                        tx_d  = {tx_q[6:0], 1'b0};
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_RACK: if (scl_rise) begin
                    if (sda_lvl == I2C_NACK) begin
                        state_d = ST_IGNORE;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        rd_d    = 1'b1;
                        phase_d = 1'b1;
                    end
                end else if (scl_fall && phase_q) begin
                    phase_d = 1'b0;
                    cnt_d   = 3'd0;
                    dao_d   = tx_q[7];
                    tx_d    = {tx_q[6:0], 1'b0};
                    state_d = ST_RDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 7'd0;
            tx_q    <= 8'd0;
            phase_q <= 1'b0;
            rw_q    <= 1'b0;
            dao_q   <= I2C_NACK;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            phase_q <= phase_d;
            rw_q    <= rw_d;
            dao_q   <= dao_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign i2cdao    = dao_q;
    assign regaddr   = addr_q;
    assign regwdata  = wdata_q;
    assign regwrite  = wr_q;
    assign regread   = rd_q;
    assign busy      = st_busy(state_q);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller tasks on a wired-AND SDA, and a
// strobe scoreboard fed with hand-computed register accesses.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;
    localparam logic [1:0] K_WR = 2'b01;
    localparam logic [1:0] K_RD = 2'b10;

    logic       clk;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic       sda_bus;
    logic       dao;
    logic [7:0] regaddr, regwdata, regrdata;
    logic       regwrite, regread, busy;
    logic [3:0] state_dbg;
    logic [7:0] mem [256];

    logic [17:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;

    assign sda_bus  = m_sda & dao;
    assign regrdata = mem[regaddr];

    i2c_target #(.DEVADDR(7'h20)) dut (
        .CLOCK(clk), .RESET_N(rst_n), .i2cclk(m_scl), .i2cdai(sda_bus), .i2cdao(dao),
        .regaddr(regaddr), .regwdata(regwdata), .regwrite(regwrite), .regread(regread),
        .regrdata(regrdata), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe pops one expected {kind, regaddr, data}
    always @(negedge clk) begin
        if (rst_n && (regwrite || regread)) begin
            logic [17:0] act;
            act = regwrite ? {K_WR, regaddr, regwdata} : {K_RD, regaddr, 8'h00};
            if (regwrite && regread) check("strobe_overlap", 32'd1, 32'd0);
            else if ((regwrite && prev_wr) || (regread && prev_rd)) check("strobe_width", 32'd2, 32'd1);
            else if (exp_q.size() == 0) check("unexpected_strobe", {14'd0, act}, 32'd0);
            else check("strobe", {14'd0, act}, {14'd0, exp_q.pop_front()});
        end
        prev_wr = regwrite;
        prev_rd = regread;
    end

    // Controller driver tasks; each bit begins and ends with SCL low
    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        wq(); m_sda = b;
        wq(); m_scl = 1'b1;
        wq();
        wq(); m_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wq(); m_sda = 1'b1;
        wq(); m_scl = 1'b1;
        wq(); b = sda_bus;
        wq(); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        wq(); m_sda = 1'b1;
        wq(); m_scl = 1'b1;
        wq(); m_sda = 1'b0;
        wq(); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wq(); m_sda = 1'b0;
        wq(); m_scl = 1'b1;
        wq(); m_sda = 1'b1;
        wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) read_bit(b[i]);
        send_bit(ack_bit);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic       bit_v;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h77;
        mem[8'h11] = 8'h88;
        mem[8'h30] = 8'hA6;
        m_scl = 1'b1;
        m_sda = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_dao", {31'd0, dao}, 32'd1);
        check("rst_regaddr", {24'd0, regaddr}, 32'h00);
        check("rst_regwdata", {24'd0, regwdata}, 32'h00);
        check("rst_strobes", {30'd0, regwrite, regread}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {28'd0, state_dbg}, {28'd0, ST_IDLE});
        rst_n = 1'b1;
        wq();

        // Write 05h<-A5h, 06h<-3Ch
        exp_q.push_back({K_WR, 8'h05, 8'hA5});
        exp_q.push_back({K_WR, 8'h06, 8'h3C});
        i2c_start();
        check("w_start_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h40, ack); check("w_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h05, ack); check("w_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hA5, ack); check("w_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h3C, ack); check("w_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("w_state", {28'd0, state_dbg}, {28'd0, ST_IDLE});
        check("w_regaddr", {24'd0, regaddr}, 32'h07);
        check("w_dao", {31'd0, dao}, 32'd1);

        // Pointer 10h, repeated START, read 77h (ACK) then 88h (NACK)
        exp_q.push_back({K_RD, 8'h10, 8'h00});
        exp_q.push_back({K_RD, 8'h11, 8'h00});
        i2c_start();
        write_byte(8'h40, ack); check("r_addrw_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h10, ack); check("r_ptr_ack", {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'h41, ack); check("r_addrr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b0, rb); check("r_byte0", {24'd0, rb}, 32'h77);
        read_byte(1'b1, rb); check("r_byte1", {24'd0, rb}, 32'h88);
        check("r_nack_state", {28'd0, state_dbg}, {28'd0, ST_IGNORE});
        check("r_nack_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
        check("r_regaddr", {24'd0, regaddr}, 32'h11);

        // Address 21h is not ours
        i2c_start();
        write_byte(8'h42, ack); check("na_addr_nack", {31'd0, ack}, 32'd1);
        check("na_state", {28'd0, state_dbg}, {28'd0, ST_IGNORE});
        check("na_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h55, ack); check("na_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("na_idle", {28'd0, state_dbg}, {28'd0, ST_IDLE});

        // Pointer FFh wraps to 00h after one data byte
        exp_q.push_back({K_WR, 8'hFF, 8'h5A});
        i2c_start();
        write_byte(8'h40, ack); check("wrap_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hFF, ack); check("wrap_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack); check("wrap_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("wrap_regaddr", {24'd0, regaddr}, 32'h00);
        check("wrap_regwdata", {24'd0, regwdata}, 32'h5A);

        // Reset during 4th data bit of a read of A6h (bits 1,0,1,0...)
        exp_q.push_back({K_RD, 8'h30, 8'h00});
        i2c_start();
        write_byte(8'h40, ack);
        write_byte(8'h30, ack);
        i2c_start();
        write_byte(8'h41, ack); check("rst_rd_ack", {31'd0, ack}, 32'd0);
        read_bit(bit_v); check("rst_rd_b7", {31'd0, bit_v}, 32'd1);
        read_bit(bit_v); check("rst_rd_b6", {31'd0, bit_v}, 32'd0);
        read_bit(bit_v); check("rst_rd_b5", {31'd0, bit_v}, 32'd1);
        wq(); m_sda = 1'b1;
        wq(); m_scl = 1'b1;
        wq();
        check("rst_rd_b4_drive", {31'd0, dao}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_dao", {31'd0, dao}, 32'd1);
        check("rst_mid_state", {28'd0, state_dbg}, {28'd0, ST_IDLE});
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wq();
        i2c_start();
        write_byte(8'h40, ack); check("post_rst_ack", {31'd0, ack}, 32'd0);
        i2c_stop();

        // STOP in the middle of a data byte: no write
        i2c_start();
        write_byte(8'h40, ack);
        write_byte(8'h07, ack); check("abort_ptr_ack", {31'd0, ack}, 32'd0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("abort_mid_state", {28'd0, state_dbg}, {28'd0, ST_WDATA});
        i2c_stop();
        check("abort_state", {28'd0, state_dbg}, {28'd0, ST_IDLE});
        check("abort_dao", {31'd0, dao}, 32'd1);
        check("abort_regaddr", {24'd0, regaddr}, 32'h07);
        check("abort_regwdata", {24'd0, regwdata}, 32'h00);

        wq();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
